// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard, stall and forwarding controller for the in-order MIPS
//               pipeline. Tracks every in-flight destination register from EX
//               through the last bypassable writeback slot. It generates:
//                 - the load-use stall,
//                 - branch/jump/exception flushes,
//                 - the ALU operand bypass selects.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   REG_AW      register address width
//   FWD_DEPTH   number of post-EX stages with a bypass path
//               (slot 1 = EX_MEM, slot FWD_DEPTH = last writeback slot)
//   LOAD_READY  first slot index at which load data may be bypassed
// Ports
//   clk           in   clock
//   reset         in   asynchronous reset, active low
//   id_valid      in   ID holds a real instruction
//   id_rs/id_rt   in   ID source register addresses
//   id_use_rs/rt  in   ID instruction actually reads rs / rt
//   id_wr_en      in   ID instruction writes a register
//   id_wr_addr    in   ID destination (after RegDst resolution)
//   id_is_load    in   ID instruction is a load
//   id_jump       in   jump / jr decoded in ID
//   ex_br_taken   in   branch resolved taken in EX
//   exc_req       in   interrupt / exception entry
//   stall         out  hold PC and IF_ID, bubble into ID_EX
//   flush_if_id   out  clear IF_ID
//   flush_id_ex   out  clear ID_EX
//   fwd_a_sel     out  operand A source (0 = register file, k = slot k)
//   fwd_b_sel     out  operand B source, same encoding
//   stall_cnt     out  saturating stall-cycle counter  (HAZ_STATS_EN only)
//   flush_cnt     out  saturating flush-cycle counter  (HAZ_STATS_EN only)
// Configuration
//   Define HAZ_STATS_EN to add the stall_cnt / flush_cnt statistics ports.
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_READY = 2,
  localparam int FSW       = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_wr_en,
  input  logic [REG_AW-1:0] id_wr_addr,
  input  logic              id_is_load,
  input  logic              id_jump,
  input  logic              ex_br_taken,
  input  logic              exc_req,
  output logic              stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [FSW-1:0]    fwd_a_sel,
  output logic [FSW-1:0]    fwd_b_sel
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  // --------------------------------------------------------------------------
  // Tracking slot: one in-flight instruction's destination information.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic              v;
    logic              wr_en;
    logic [REG_AW-1:0] addr;
    logic              is_load;
  } slot_t;

  slot_t slot_q [0:FWD_DEPTH];
  slot_t slot_d [0:FWD_DEPTH];

  // Source operands of the instruction currently in EX (slot 0 only).
  logic [REG_AW-1:0] ex_rs_q,     ex_rs_d;
  logic [REG_AW-1:0] ex_rt_q,     ex_rt_d;
  logic              ex_use_rs_q, ex_use_rs_d;
  logic              ex_use_rt_q, ex_use_rt_d;

  // Internal, un-gated control terms.
  logic              flush_req;
  logic              hazard;
  logic              stall_int;
  logic              load_id;
  logic [FSW-1:0]    sel_a;
  logic [FSW-1:0]    sel_b;

  // A slot produces register a only if it is a live writer of a non-zero
  // register; $0 is hardwired and must never be bypassed.
  function automatic logic slot_match(input slot_t s, input logic [REG_AW-1:0] a);
    return s.v & s.wr_en & (s.addr == a) & (a != '0);
  endfunction

  // Load data only exists from slot LOAD_READY onward; ALU results are
  // available from every post-EX slot.
  function automatic logic slot_ready(input int k, input logic is_load);
    return !is_load || (k >= LOAD_READY);
  endfunction

  // --------------------------------------------------------------------------
  // Flush / stall resolution
  // --------------------------------------------------------------------------
  assign flush_req = ex_br_taken | exc_req;

  // A load in slot k reaches slot k+1 when the ID instruction reaches EX; if
  // that is still short of LOAD_READY the consumer cannot be fed and must wait.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      if (slot_q[k].is_load && ((k + 1) < LOAD_READY)) begin
        if ((id_use_rs && slot_match(slot_q[k], id_rs)) ||
            (id_use_rt && slot_match(slot_q[k], id_rt))) begin
          hazard = 1'b1;
        end
      end
    end
  end

  // A flush kills the ID instruction anyway, so it overrides the stall.
  assign stall_int = id_valid & hazard & ~flush_req;

  // Slot 0 captures the ID instruction only when it really advances into EX.
  assign load_id = id_valid & ~stall_int & ~flush_req;

  // Outputs are forced low while reset is asserted; this also aborts an
  // in-progress stall immediately, without waiting for a clock edge.
  assign stall       = reset & stall_int;
  assign flush_id_ex = reset & flush_req;
  // A stalled jump holds off its IF_ID flush until it actually leaves ID.
  // When a taken branch coincides with a jump, the jump is on the wrong path
  // and is simply covered by the branch flush.
  assign flush_if_id = reset & (flush_req | (id_jump & ~stall_int));

  // --------------------------------------------------------------------------
  // Tracking shift register: next-state
  // --------------------------------------------------------------------------
  always_comb begin
    slot_d[0]   = '0;
    ex_rs_d     = '0;
    ex_rt_d     = '0;
    ex_use_rs_d = 1'b0;
    ex_use_rt_d = 1'b0;
    if (load_id) begin
      slot_d[0].v       = 1'b1;
      slot_d[0].wr_en   = id_wr_en;
      slot_d[0].addr    = id_wr_addr;
      slot_d[0].is_load = id_is_load;
      ex_rs_d           = id_rs;
      ex_rt_d           = id_rt;
      ex_use_rs_d       = id_use_rs;
      ex_use_rt_d       = id_use_rt;
    end
    // Older slots advance one stage; the oldest entry falls off the end.
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      slot_d[k] = slot_q[k-1];
    end
  end

  // --------------------------------------------------------------------------
  // Tracking shift register: state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        slot_q[k] <= '0;
      end
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_use_rs_q <= 1'b0;
      ex_use_rt_q <= 1'b0;
    end else begin
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_use_rs_q <= ex_use_rs_d;
      ex_use_rt_q <= ex_use_rt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Operand bypass selection for the instruction in EX.
  // Scanning from the oldest slot toward the youngest lets the youngest
  // ready producer overwrite any older one.
  // --------------------------------------------------------------------------
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (ex_use_rs_q && slot_match(slot_q[k], ex_rs_q) &&
          slot_ready(k, slot_q[k].is_load)) begin
        sel_a = FSW'(k);
      end
      if (ex_use_rt_q && slot_match(slot_q[k], ex_rt_q) &&
          slot_ready(k, slot_q[k].is_load)) begin
        sel_b = FSW'(k);
      end
    end
  end

  assign fwd_a_sel = reset ? sel_a : '0;
  assign fwd_b_sel = reset ? sel_b : '0;

`ifdef HAZ_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating statistics counters
  // --------------------------------------------------------------------------
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if ((flush_id_ex || flush_if_id) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench for pipe_hazard_ctrl.
//               - u_dut  uses the default configuration (FWD_DEPTH=2, LOAD_READY=2).
//               - u_dut3 uses FWD_DEPTH=3, LOAD_READY=3.
//               Both instances share all inputs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_wr_en;
  logic [4:0] id_wr_addr;
  logic       id_is_load;
  logic       id_jump;
  logic       ex_br_taken;
  logic       exc_req;

  logic       stall,  flush_if_id,  flush_id_ex;
  logic [1:0] fwd_a_sel,  fwd_b_sel;
  logic       stall3, flush_if_id3, flush_id_ex3;
  logic [1:0] fwd_a_sel3, fwd_b_sel3;
`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt,  flush_cnt;
  logic [31:0] stall_cnt3, flush_cnt3;
`endif

  int n_chk;
  int n_err;

  pipe_hazard_ctrl u_dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_wr_en    (id_wr_en),
    .id_wr_addr  (id_wr_addr),
    .id_is_load  (id_is_load),
    .id_jump     (id_jump),
    .ex_br_taken (ex_br_taken),
    .exc_req     (exc_req),
    .stall       (stall),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel)
`ifdef HAZ_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  pipe_hazard_ctrl #(
    .REG_AW     (5),
    .FWD_DEPTH  (3),
    .LOAD_READY (3)
  ) u_dut3 (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_wr_en    (id_wr_en),
    .id_wr_addr  (id_wr_addr),
    .id_is_load  (id_is_load),
    .id_jump     (id_jump),
    .ex_br_taken (ex_br_taken),
    .exc_req     (exc_req),
    .stall       (stall3),
    .flush_if_id (flush_if_id3),
    .flush_id_ex (flush_id_ex3),
    .fwd_a_sel   (fwd_a_sel3),
    .fwd_b_sel   (fwd_b_sel3)
`ifdef HAZ_STATS_EN
    ,
    .stall_cnt   (stall_cnt3),
    .flush_cnt   (flush_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input int v, input int rs, input int rt, input int urs,
                        input int urt, input int we, input int wa, input int ld,
                        input int jmp);
    id_valid   = (v != 0);
    id_rs      = 5'(rs);
    id_rt      = 5'(rt);
    id_use_rs  = (urs != 0);
    id_use_rt  = (urt != 0);
    id_wr_en   = (we != 0);
    id_wr_addr = 5'(wa);
    id_is_load = (ld != 0);
    id_jump    = (jmp != 0);
  endtask

  task automatic id_nop();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    exc_req = 1'b0;
    // Reset outranks flush: a taken branch and a jump during reset show nothing.
    id_set(1, 8, 9, 1, 1, 1, 8, 1, 1);
    ex_br_taken = 1'b1;
    #3;
    chk("rst_stall",    32'(stall),       0);
    chk("rst_flush_if", 32'(flush_if_id), 0);
    chk("rst_flush_ex", 32'(flush_id_ex), 0);
    chk("rst_fwd_a",    32'(fwd_a_sel),   0);
    chk("rst_fwd_b",    32'(fwd_b_sel),   0);
    ex_br_taken = 1'b0;
    id_nop();
    tick();
    tick();
    reset = 1'b1;

    // c0: lw $8
    id_set(1, 29, 0, 1, 0, 1, 8, 1, 0); #1;
    chk("c0_stall", 32'(stall), 0);
    tick();
    // c1: add $10,$8,$9 -> load-use stall
    id_set(1, 8, 9, 1, 1, 1, 10, 0, 0); #1;
    chk("c1_stall",    32'(stall),       1);
    chk("c1_flush_if", 32'(flush_if_id), 0);
    chk("c1_flush_ex", 32'(flush_id_ex), 0);
    chk("c1_fwd_a",    32'(fwd_a_sel),   0);
    tick();
    // c2: stall lasts exactly one cycle
    #1;
    chk("c2_stall", 32'(stall), 0);
    tick();
    // c3: consumer in EX, load in slot 2; ID = add $9
    id_set(1, 1, 2, 1, 1, 1, 9, 0, 0); #1;
    chk("c3_fwd_a", 32'(fwd_a_sel), 2);
    chk("c3_fwd_b", 32'(fwd_b_sel), 0);
    chk("c3_stall", 32'(stall),     0);
    tick();
    // c4: sub $11,$3,$9 right behind add $9 -> no stall
    id_set(1, 3, 9, 1, 1, 1, 11, 0, 0); #1;
    chk("c4_stall", 32'(stall),     0);
    chk("c4_fwd_a", 32'(fwd_a_sel), 0);
    tick();
    // c5: sub in EX, add $9 in slot 1; ID = or $12,$4,$9
    id_set(1, 4, 9, 1, 1, 1, 12, 0, 0); #1;
    chk("c5_fwd_b", 32'(fwd_b_sel), 1);
    chk("c5_fwd_a", 32'(fwd_a_sel), 0);
    tick();
    // c6: or in EX, add $9 in slot 2; ID = writer of $0
    id_set(1, 0, 0, 0, 0, 1, 0, 0, 0); #1;
    chk("c6_fwd_b", 32'(fwd_b_sel), 2);
    chk("c6_fwd_a", 32'(fwd_a_sel), 0);
    tick();
    // c7: second writer of $0
    tick();
    // c8: consumer reading $0 twice
    id_set(1, 0, 0, 1, 1, 0, 0, 0, 0);
    tick();
    // c9: $0 consumer in EX with $0 producers in slots 1,2; ID = writer $5
    id_set(1, 0, 0, 0, 0, 1, 5, 0, 0); #1;
    chk("c9_zero_fwd_a", 32'(fwd_a_sel), 0);
    chk("c9_zero_fwd_b", 32'(fwd_b_sel), 0);
    tick();
    // c10: second writer $5
    tick();
    // c11: consumer rs=5 used, rt=5 not used
    id_set(1, 5, 5, 1, 0, 0, 0, 0, 0);
    tick();
    // c12: youngest $5 producer wins; ID = lw $8
    id_set(1, 29, 0, 1, 0, 1, 8, 1, 0); #1;
    chk("c12_young_fwd_a", 32'(fwd_a_sel), 1);
    chk("c12_unused_fwd_b", 32'(fwd_b_sel), 0);
    chk("c12_stall", 32'(stall), 0);
    tick();
    // c13: load-use (lw $7,($8)) + jump, together with a taken branch
    id_set(1, 8, 0, 1, 0, 1, 7, 1, 1);
    ex_br_taken = 1'b1; #1;
    chk("c13_stall",    32'(stall),       0);
    chk("c13_flush_if", 32'(flush_if_id), 1);
    chk("c13_flush_ex", 32'(flush_id_ex), 1);
    tick();
    // c14: slot 0 is a bubble, so a reader of $7 must not stall; ID = lw $8,($7)
    ex_br_taken = 1'b0;
    id_set(1, 7, 0, 1, 0, 1, 8, 1, 0); #1;
    chk("c14_bubble_stall", 32'(stall), 0);
    chk("c14_flush_if", 32'(flush_if_id), 0);
    chk("c14_flush_ex", 32'(flush_id_ex), 0);
    tick();
    // c15: jr $8 behind the load -> stalled, no IF_ID flush yet
    id_set(1, 8, 0, 1, 0, 0, 0, 0, 1); #1;
    chk("c15_stall",    32'(stall),       1);
    chk("c15_flush_if", 32'(flush_if_id), 0);
    chk("c15_flush_ex", 32'(flush_id_ex), 0);
    tick();
    // c16: stall released, jump now flushes IF_ID only
    #1;
    chk("c16_stall",    32'(stall),       0);
    chk("c16_flush_if", 32'(flush_if_id), 1);
    chk("c16_flush_ex", 32'(flush_id_ex), 0);
    tick();
    // c17: exception entry
    id_nop();
    exc_req = 1'b1; #1;
    chk("c17_exc_flush_ex", 32'(flush_id_ex), 1);
    chk("c17_exc_flush_if", 32'(flush_if_id), 1);
    tick();
    exc_req = 1'b0;
    // c18: lw $8
    id_set(1, 29, 0, 1, 0, 1, 8, 1, 0);
    tick();
    // c19: consumer -> stall, then reset mid-cycle
    id_set(1, 8, 0, 1, 0, 1, 10, 0, 0); #1;
    chk("c19_stall", 32'(stall), 1);
`ifdef HAZ_STATS_EN
    chk("c19_stall_cnt", stall_cnt, 2);
    chk("c19_flush_cnt", flush_cnt, 3);
`endif
    #2;
    reset = 1'b0; #1;
    chk("arst_stall",    32'(stall),       0);
    chk("arst_flush_if", 32'(flush_if_id), 0);
    chk("arst_flush_ex", 32'(flush_id_ex), 0);
    chk("arst_fwd_a",    32'(fwd_a_sel),   0);
`ifdef HAZ_STATS_EN
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_flush_cnt", flush_cnt, 0);
`endif
    // Releasing reset with the consumer still in ID: slots are empty.
    reset = 1'b1; #1;
    chk("arst_slots_clear", 32'(stall), 0);
    id_nop();
    tick();

    // ---- FWD_DEPTH=3, LOAD_READY=3 instance ----
    // e0: lw $8
    id_set(1, 29, 0, 1, 0, 1, 8, 1, 0); #1;
    chk("e0_stall3", 32'(stall3), 0);
    tick();
    // e1..e3: immediate consumer stalls two cycles
    id_set(1, 8, 0, 1, 0, 1, 10, 0, 0); #1;
    chk("e1_stall3", 32'(stall3), 1);
    tick();
    #1;
    chk("e2_stall3", 32'(stall3), 1);
    tick();
    #1;
    chk("e3_stall3", 32'(stall3), 0);
    tick();
    // e4: consumer in EX, load in slot 3; ID = lw $8
    id_set(1, 29, 0, 1, 0, 1, 8, 1, 0); #1;
    chk("e4_fwd_a3", 32'(fwd_a_sel3), 3);
    chk("e4_fwd_b3", 32'(fwd_b_sel3), 0);
`ifdef HAZ_STATS_EN
    chk("e4_stall_cnt3", stall_cnt3, 2);
`endif
    tick();
    // e5: independent instruction
    id_set(1, 1, 2, 1, 1, 1, 11, 0, 0); #1;
    chk("e5_stall3", 32'(stall3), 0);
    tick();
    // e6..e7: consumer one behind -> single stall
    id_set(1, 8, 0, 1, 0, 1, 10, 0, 0); #1;
    chk("e6_stall3", 32'(stall3), 1);
    tick();
    #1;
    chk("e7_stall3", 32'(stall3), 0);
    tick();
    // e8: consumer in EX with the load in slot 3
    id_nop(); #1;
    chk("e8_fwd_a3", 32'(fwd_a_sel3), 3);
`ifdef HAZ_STATS_EN
    chk("e8_stall_cnt3", stall_cnt3, 3);
    chk("e8_flush_cnt3", flush_cnt3, 0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
